// File: rtl/ic_dest_sched_if.sv
// ic_dest_sched_if: request/grant bundle between the source partitions and
// one destination-partition stage-1 scheduler.
// The master modport drives requests and dequeues.
// The slave modport is the scheduler, which returns grants and status.
interface ic_dest_sched_if #(
    parameter int NSP   = 8,
    parameter int SEL_W = $clog2(NSP)
);
    logic                 enable;
    logic [NSP-1:0]       src_valid;
    logic [NSP-1:0]       src_valid_urgent;
    logic [NSP-1:0]       src_dest_match;
    logic                 dequeue;
    logic [NSP-1:0]       part_sel;
    logic [SEL_W-1:0]     sel_encoded;
    logic                 sel_valid;
    logic [3:0]           credit_count;
    logic                 error;
    logic [15:0]          stall_count;

    modport master (
        output enable, src_valid, src_valid_urgent, src_dest_match, dequeue,
        input  part_sel, sel_encoded, sel_valid, credit_count, error, stall_count
    );

    modport slave (
        input  enable, src_valid, src_valid_urgent, src_dest_match, dequeue,
        output part_sel, sel_encoded, sel_valid, credit_count, error, stall_count
    );
endinterface

// File: rtl/ic_dest_sched.sv
// ic_dest_sched: stage-1 source-partition scheduler for one destination partition.
// Three priority classes are used: starved, then urgent, then normal.
// A single shared round-robin pointer resolves ties within whichever class wins.
// Grants are credit-gated so the destination buffer cannot overflow.
// Optional feature macro: IC_SCHED_STATS_EN enables the credit-stall cycle counter.
// Without that macro, stall_count is tied to zero.
module ic_dest_sched #(
    parameter int NSP     = 8,
    parameter int CREDITS = 2,
    parameter int AGE_MAX = 15
) (
    input  logic               clock,
    input  logic               reset,
    ic_dest_sched_if.slave     bus
);
    localparam int              SEL_W     = $clog2(NSP);
    localparam logic [3:0]      CRED_INIT = 4'(CREDITS);
    localparam logic [7:0]      AGE_SAT   = 8'(AGE_MAX);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NSP - 1);

    logic [NSP-1:0]   cand;
    logic [NSP-1:0]   starved;
    logic [NSP-1:0]   urgent;
    logic [NSP-1:0]   cls;
    logic [7:0]       age [NSP];
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] scan_idx;
    logic [3:0]       credit;
    logic             err_q;
    logic             gnt_ok;
    logic             gnt_found;
    logic [SEL_W-1:0] gnt_idx;
    logic [NSP-1:0]   gnt_vec;
    logic [SEL_W-1:0] sel_idx_p1;
    logic             vld_p1;
    logic             credit_zero;
    logic             overflow;

    assign cand        = bus.src_valid & bus.src_dest_match;
    assign urgent      = cand & bus.src_valid_urgent;
    assign credit_zero = (credit == 4'd0);

    // Starved class: candidates whose wait counter has saturated.
    always_comb begin
        starved = '0;
        for (int i = 0; i < NSP; i++) begin
            starved[i] = cand[i] && (age[i] == AGE_SAT);
        end
    end

    // Pick the highest non-empty priority class.
    always_comb begin
        if (|starved)     cls = starved;
        else if (|urgent) cls = urgent;
        else              cls = cand;
    end

    // Round-robin search of the chosen class starting at ptr, wrapping at NSP.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = ptr;
        for (int i = 0; i < NSP; i++) begin
            if (!gnt_found && cls[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
            scan_idx = (scan_idx == LAST_IDX) ? '0 : scan_idx + SEL_W'(1);
        end
    end

    // Grant qualification: reset kills any in-flight grant at once.
    // Credits come only from the register, so a same-cycle dequeue cannot unblock a grant.
    assign gnt_ok   = bus.enable && !reset && !credit_zero && (|cand) && gnt_found;
    assign gnt_vec  = gnt_ok ? (NSP'(1) << gnt_idx) : '0;
    assign overflow = bus.dequeue && !gnt_ok && (credit == CRED_INIT);

    assign bus.part_sel = gnt_vec;

    // Shared round-robin pointer advances past each granted source.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (bus.enable && gnt_ok) begin
            ptr <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + SEL_W'(1);
        end
    end

    // Per-source wait counters; zero-credit cycles still count as waiting.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NSP; i++) age[i] <= '0;
        end else if (bus.enable) begin
            for (int i = 0; i < NSP; i++) begin
                if (!cand[i] || gnt_vec[i]) age[i] <= '0;
                else if (age[i] != AGE_SAT) age[i] <= age[i] + 8'd1;
            end
        end
    end

    // Credit tracking; a dequeue with a full credit pool is held and flagged.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            credit <= CRED_INIT;
        end else if (bus.enable) begin
            if (gnt_ok && !bus.dequeue)      credit <= credit - 4'd1;
            else if (!gnt_ok && bus.dequeue && !overflow) credit <= credit + 4'd1;
        end
    end

    // Sticky overflow error, cleared only by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                       err_q <= 1'b0;
        else if (bus.enable && overflow) err_q <= 1'b1;
    end

    // Stage 1 -> stage 2: encoded select and its valid for the destination mux.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sel_idx_p1 <= '0;
            vld_p1     <= 1'b0;
        end else if (bus.enable) begin
            if (gnt_ok) sel_idx_p1 <= gnt_idx;
            vld_p1 <= gnt_ok;
        end
    end

    assign bus.sel_encoded  = sel_idx_p1;
    assign bus.sel_valid    = vld_p1;
    assign bus.credit_count = credit;
    assign bus.error        = err_q;

`ifdef IC_SCHED_STATS_EN
    logic [15:0] stall_q;

    // Saturating count of enabled cycles where a candidate waits on zero credits.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if (bus.enable && (|cand) && credit_zero && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign bus.stall_count = stall_q;
`else
    assign bus.stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_ic_dest_sched.sv
// tb_ic_dest_sched: scenario tasks plus randomized traffic, checked against a
// rule-level reference model of the scheduler.
module tb_ic_dest_sched;
    localparam int NSP     = 8;
    localparam int CREDITS = 2;
    localparam int AGE_MAX = 15;
    localparam int SEL_W   = $clog2(NSP);

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    ic_dest_sched_if #(.NSP(NSP)) bus ();

    ic_dest_sched #(.NSP(NSP), .CREDITS(CREDITS), .AGE_MAX(AGE_MAX)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int m_ptr, m_credit, m_err, m_sel, m_vld, m_stall;
    int m_age [NSP];

    function automatic void model_reset();
        m_ptr = 0; m_credit = CREDITS; m_err = 0; m_sel = 0; m_vld = 0; m_stall = 0;
        for (int k = 0; k < NSP; k++) m_age[k] = 0;
    endfunction

    function automatic logic [15:0] stall_exp();
`ifdef IC_SCHED_STATS_EN
        return 16'(m_stall);
`else
        return 16'h0000;
`endif
    endfunction

    // Winner = member of the best non-empty class at the smallest cyclic distance from ptr.
    function automatic int model_pick();
        logic [NSP-1:0] cand, pool, st;
        int best, bestd, d;
        cand = bus.src_valid & bus.src_dest_match;
        if (!bus.enable || m_credit == 0 || cand == '0) return -1;
        st = '0;
        for (int k = 0; k < NSP; k++) st[k] = cand[k] && (m_age[k] == AGE_MAX);
        if (st != '0) pool = st;
        else if ((cand & bus.src_valid_urgent) != '0) pool = cand & bus.src_valid_urgent;
        else pool = cand;
        best = -1; bestd = NSP;
        for (int k = 0; k < NSP; k++) begin
            d = (k - m_ptr + NSP) % NSP;
            if (pool[k] && d < bestd) begin best = k; bestd = d; end
        end
        return best;
    endfunction

    function automatic void model_update(input int g);
        logic [NSP-1:0] cand;
        if (!bus.enable) return;
        cand = bus.src_valid & bus.src_dest_match;
        if (cand != '0 && m_credit == 0 && m_stall < 65535) m_stall++;
        for (int k = 0; k < NSP; k++) begin
            if (!cand[k] || k == g) m_age[k] = 0;
            else if (m_age[k] < AGE_MAX) m_age[k]++;
        end
        if (g >= 0 && !bus.dequeue) m_credit--;
        else if (g < 0 && bus.dequeue) begin
            if (m_credit == CREDITS) m_err = 1;
            else m_credit++;
        end
        if (g >= 0) begin m_ptr = (g + 1) % NSP; m_sel = g; end
        m_vld = (g >= 0) ? 1 : 0;
    endfunction

    // One clock: inputs already driven after a negedge. Returns the observed and
    // model-expected part_sel, advances the model at the edge, ends at the next negedge.
    task automatic step(output logic [NSP-1:0] got, output logic [NSP-1:0] exp);
        int g;
        #1;
        g   = model_pick();
        exp = (g < 0) ? '0 : (NSP'(1) << g);
        got = bus.part_sel;
        @(posedge clock);
        model_update(g);
        @(negedge clock);
    endtask

    task automatic drive(input logic en, input logic [NSP-1:0] v, input logic [NSP-1:0] u,
                         input logic [NSP-1:0] m, input logic dq);
        bus.enable = en; bus.src_valid = v; bus.src_valid_urgent = u;
        bus.src_dest_match = m; bus.dequeue = dq;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b1, '0, '0, '0, 1'b0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 8'hFF, 8'h00, 8'hFF, 1'b0);
        #2;
        vectors++;
        if (bus.part_sel !== 8'h00) begin miscompares++; $display("FAIL reset_part_sel got %h want 00", bus.part_sel); end
        vectors++;
        if (bus.sel_valid !== 1'b0 || bus.sel_encoded !== 3'd0) begin
            miscompares++; $display("FAIL reset_sel got v=%b e=%0d want v=0 e=0", bus.sel_valid, bus.sel_encoded);
        end
        vectors++;
        if (bus.credit_count !== 4'd2 || bus.error !== 1'b0 || bus.stall_count !== 16'h0) begin
            miscompares++; $display("FAIL reset_status got c=%0d e=%b s=%0d want c=2 e=0 s=0",
                                    bus.credit_count, bus.error, bus.stall_count);
        end
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_round_robin();
        logic [NSP-1:0] got, exp;
        do_reset();
        drive(1'b1, 8'hFF, 8'h00, 8'hFF, 1'b1);
        for (int c = 0; c < 9; c++) begin
            step(got, exp);
            vectors++;
            if (got !== exp || got !== (8'h01 << (c % NSP))) begin
                miscompares++; $display("FAIL rr_grant c=%0d got %h want %h", c, got, 8'h01 << (c % NSP));
            end
            vectors++;
            if (bus.sel_valid !== 1'b1 || bus.sel_encoded !== 3'(c % NSP) || bus.credit_count !== 4'd2) begin
                miscompares++; $display("FAIL rr_regs c=%0d got v=%b e=%0d cr=%0d want v=1 e=%0d cr=2",
                                        c, bus.sel_valid, bus.sel_encoded, bus.credit_count, c % NSP);
            end
        end
    endtask

    task automatic test_starvation();
        logic [NSP-1:0] got, exp;
        do_reset();
        drive(1'b1, 8'h81, 8'h80, 8'hFF, 1'b1);
        for (int c = 0; c < 20; c++) begin
            step(got, exp);
            vectors++;
            if (got !== exp || got !== ((c == 15) ? 8'h01 : 8'h80)) begin
                miscompares++; $display("FAIL starve_grant c=%0d got %h want %h", c, got, (c == 15) ? 8'h01 : 8'h80);
            end
        end
    endtask

    task automatic test_credits();
        logic [NSP-1:0] got, exp;
        logic [NSP-1:0] want [5] = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h01};
        logic [3:0]     wcr  [5] = '{4'd1, 4'd0, 4'd0, 4'd1, 4'd0};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 8'h01, 8'h00, 8'h01, (c == 3));
            step(got, exp);
            vectors++;
            if (got !== exp || got !== want[c] || bus.credit_count !== wcr[c]) begin
                miscompares++; $display("FAIL credit_gate c=%0d got sel=%h cr=%0d want sel=%h cr=%0d",
                                        c, got, bus.credit_count, want[c], wcr[c]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [NSP-1:0] got, exp;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 8'h00, 8'h00, 8'h00, (c == 0));
            step(got, exp);
            vectors++;
            if (bus.error !== 1'b1 || bus.credit_count !== 4'd2 || bus.error !== 1'(m_err)) begin
                miscompares++; $display("FAIL overflow c=%0d got err=%b cr=%0d want err=1 cr=2",
                                        c, bus.error, bus.credit_count);
            end
        end
    endtask

    task automatic test_enable_freeze();
        logic [NSP-1:0] got, exp;
        do_reset();
        drive(1'b1, 8'h08, 8'h00, 8'hFF, 1'b1);
        step(got, exp);
        vectors++;
        if (got !== 8'h08 || bus.sel_encoded !== 3'd3) begin
            miscompares++; $display("FAIL freeze_first got sel=%h enc=%0d want sel=08 enc=3", got, bus.sel_encoded);
        end
        drive(1'b0, 8'hFF, 8'h00, 8'hFF, 1'b1);
        for (int c = 0; c < 5; c++) begin
            step(got, exp);
            vectors++;
            if (got !== 8'h00 || bus.sel_encoded !== 3'd3 || bus.sel_valid !== 1'b1 ||
                bus.credit_count !== 4'd2 || bus.error !== 1'b0) begin
                miscompares++; $display("FAIL freeze_hold c=%0d got sel=%h enc=%0d v=%b cr=%0d err=%b want 00/3/1/2/0",
                                        c, got, bus.sel_encoded, bus.sel_valid, bus.credit_count, bus.error);
            end
        end
        drive(1'b1, 8'hFF, 8'h00, 8'hFF, 1'b1);
        step(got, exp);
        vectors++;
        if (got !== 8'h10 || got !== exp) begin
            miscompares++; $display("FAIL freeze_resume got %h want 10", got);
        end
    endtask

    task automatic test_stall_count();
        logic [NSP-1:0] got, exp;
        do_reset();
        drive(1'b1, 8'h01, 8'h00, 8'hFF, 1'b0);
        step(got, exp);
        step(got, exp);
        drive(1'b1, 8'h10, 8'h00, 8'hFF, 1'b0);
        for (int c = 0; c < 10; c++) step(got, exp);
        vectors++;
`ifdef IC_SCHED_STATS_EN
        if (bus.stall_count !== 16'd10 || bus.stall_count !== stall_exp()) begin
            miscompares++; $display("FAIL stall_count got %0d want 10", bus.stall_count);
        end
`else
        if (bus.stall_count !== 16'd0) begin
            miscompares++; $display("FAIL stall_count got %0d want 0", bus.stall_count);
        end
`endif
    endtask

    task automatic test_mid_reset();
        logic [NSP-1:0] got, exp;
        do_reset();
        drive(1'b1, 8'hFF, 8'h00, 8'hFF, 1'b0);
        step(got, exp);
        step(got, exp);
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (bus.part_sel !== 8'h00 || bus.credit_count !== 4'd2 || bus.sel_valid !== 1'b0) begin
            miscompares++; $display("FAIL mid_reset got sel=%h cr=%0d v=%b want 00/2/0",
                                    bus.part_sel, bus.credit_count, bus.sel_valid);
        end
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        logic [NSP-1:0] got, exp;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 7) != 0), NSP'($urandom), NSP'($urandom & $urandom),
                  NSP'($urandom | $urandom), ($urandom_range(0, 2) == 0));
            step(got, exp);
            vectors++;
            if (got !== exp) begin
                miscompares++; $display("FAIL rand_sel c=%0d got %h want %h", c, got, exp);
            end
            vectors++;
            if (bus.sel_valid !== 1'(m_vld) || bus.sel_encoded !== SEL_W'(m_sel)) begin
                miscompares++; $display("FAIL rand_stage2 c=%0d got v=%b e=%0d want v=%0d e=%0d",
                                        c, bus.sel_valid, bus.sel_encoded, m_vld, m_sel);
            end
            vectors++;
            if (bus.credit_count !== 4'(m_credit) || bus.error !== 1'(m_err) || bus.stall_count !== stall_exp()) begin
                miscompares++; $display("FAIL rand_status c=%0d got cr=%0d err=%b st=%0d want cr=%0d err=%0d st=%0d",
                                        c, bus.credit_count, bus.error, bus.stall_count, m_credit, m_err, stall_exp());
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b1, '0, '0, '0, 1'b0);
        model_reset();
        @(negedge clock);
        test_reset();
        test_round_robin();
        test_starvation();
        test_credits();
        test_overflow();
        test_enable_freeze();
        test_stall_count();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
